// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel stream filter.
// Holds the FSM state encoding, gradient guard width and saturation limit.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Signed gradient width is PIX_W + GRAD_GUARD_W: room for 4*max on each side plus sign
    localparam int GRAD_GUARD_W = 3;

    function automatic int grad_w(input int pix_w);
        return pix_w + GRAD_GUARD_W;
    endfunction

    function automatic int sat_max(input int pix_w);
        return (1 << pix_w) - 1;
    endfunction

endpackage

// File: rtl/sobel_stream_filter_if.sv
// Pixel-in / edge-out stream bundle; the filter takes the slave side.
interface sobel_stream_filter_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] pix_i;
    logic             pix_valid_i;
    logic             pix_ready_o;
    logic [PIX_W-1:0] edge_o;
    logic             edge_valid_o;
    logic             edge_ready_i;
    logic             edge_last_o;

    modport master (
        output pix_i, pix_valid_i, edge_ready_i,
        input  pix_ready_o, edge_o, edge_valid_o, edge_last_o
    );

    modport slave (
        input  pix_i, pix_valid_i, edge_ready_i,
        output pix_ready_o, edge_o, edge_valid_o, edge_last_o
    );
endinterface

// File: rtl/sobel_line_buffer.sv
// One-row pixel delay: read and write share the column address.
// Latency: exactly IMG_W writes; the read is combinational from the addressed entry.
// Backpressure: none; only advances when wr_en (the input handshake) is high.
module sobel_line_buffer #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int AW    = $clog2(IMG_W)
) (
    input  logic             clk_i,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    logic [PIX_W-1:0] mem [IMG_W];

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[addr] <= din;
    end

    assign dout = mem[addr];
endmodule

// File: rtl/sobel_stream_filter.sv
// Sobel 3x3 edge magnitude over a raster stream; SOBEL_THRESH_EN gives binary output vs thresh_i.
// Latency: 1 cycle from the triggering input handshake to edge_valid_o.
// Backpressure: input stalls whenever the single output register is full and not being taken.
module sobel_stream_filter
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
`ifdef SOBEL_THRESH_EN
    input  logic [PIX_W-1:0]     thresh_i,
`endif
    sobel_stream_filter_if.slave io,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int AW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int GRAD_W = grad_w(PIX_W);

    state_t                  state_q, state_d;
    logic [AW-1:0]           col_q;
    logic [RW-1:0]           row_q;
    logic                    in_hs, out_hs, col_last, row_last, load;
    logic [PIX_W-1:0]        lb0_dout, lb1_dout;
    // Left and middle window columns are registered; the right column arrives live
    logic [PIX_W-1:0]        win_q [3][2];
    logic signed [GRAD_W-1:0] gx, gy;
    logic [GRAD_W-1:0]       ax, ay;
    logic [GRAD_W:0]         mag;
    logic [PIX_W-1:0]        edge_nxt;

    function automatic logic signed [GRAD_W-1:0] sx(input logic [PIX_W-1:0] p);
        return $signed(GRAD_W'(p));
    endfunction

    assign io.pix_ready_o = (state_q == RUN) && (!io.edge_valid_o || io.edge_ready_i);
    assign in_hs    = io.pix_valid_i && io.pix_ready_o;
    assign out_hs   = io.edge_valid_o && io.edge_ready_i;
    assign col_last = (col_q == AW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign load     = in_hs && (row_q >= RW'(2)) && (col_q >= AW'(2));
    assign busy_o   = (state_q == RUN) || (state_q == DRAIN);
    assign done_o   = (state_q == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (in_hs && col_last && row_last) state_d = DRAIN;
            DRAIN:   if (out_hs && io.edge_last_o) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_hs) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // lb0 delays by one row, lb1 (fed from lb0) by two
    sobel_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .AW(AW)) u_lb0 (
        .clk_i(clk_i), .wr_en(in_hs), .addr(col_q), .din(io.pix_i), .dout(lb0_dout)
    );
    sobel_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .AW(AW)) u_lb1 (
        .clk_i(clk_i), .wr_en(in_hs), .addr(col_q), .din(lb0_dout), .dout(lb1_dout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 2; c++) win_q[r][c] <= '0;
        end else if (in_hs) begin
            for (int r = 0; r < 3; r++) win_q[r][0] <= win_q[r][1];
            win_q[0][1] <= lb1_dout;
            win_q[1][1] <= lb0_dout;
            win_q[2][1] <= io.pix_i;
        end
    end

    always_comb begin
        gx  = (sx(lb1_dout) + (sx(lb0_dout) <<< 1) + sx(io.pix_i))
            - (sx(win_q[0][0]) + (sx(win_q[1][0]) <<< 1) + sx(win_q[2][0]));
        gy  = (sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(io.pix_i))
            - (sx(win_q[0][0]) + (sx(win_q[0][1]) <<< 1) + sx(lb1_dout));
        ax  = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
        ay  = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
        mag = {1'b0, ax} + {1'b0, ay};
    end

`ifdef SOBEL_THRESH_EN
    assign edge_nxt = (mag >= (GRAD_W + 1)'(thresh_i)) ? {PIX_W{1'b1}} : '0;
`else
    localparam logic [GRAD_W:0] MAG_MAX = (GRAD_W + 1)'(sat_max(PIX_W));
    assign edge_nxt = (mag > MAG_MAX) ? MAG_MAX[PIX_W-1:0] : mag[PIX_W-1:0];
`endif

    // Load is only possible when the register is empty or draining this cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            io.edge_o       <= '0;
            io.edge_valid_o <= 1'b0;
            io.edge_last_o  <= 1'b0;
        end else if (load) begin
            io.edge_o       <= edge_nxt;
            io.edge_valid_o <= 1'b1;
            io.edge_last_o  <= col_last && row_last;
        end else if (out_hs) begin
            io.edge_valid_o <= 1'b0;
            io.edge_last_o  <= 1'b0;
        end
    end
endmodule

// File: doc/sobel_stream_filter.md
SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

Interface
REQ-001 Parameter PIX_W, default 8, sets the pixel bit width for input and output.
REQ-002 Parameter IMG_W, default 640, sets the image width in pixels (minimum 3).
REQ-003 Parameter IMG_H, default 480, sets the image height in pixels (minimum 3).
REQ-004 Port clk_i, input, 1 bit, is the single clock; all logic is on its rising edge.
REQ-005 Port rst_ni, input, 1 bit, is the asynchronous, active-low reset.
REQ-006 Port start_i, input, 1 bit, is a one-cycle pulse that begins a frame.
REQ-007 Port pix_i, input, PIX_W bits, is the grayscale input pixel (raster order).
REQ-008 Port pix_valid_i, input, 1 bit, marks pix_i as valid.
REQ-009 Port pix_ready_o, output, 1 bit, indicates the input pixel is accepted.
REQ-010 Port edge_o, output, PIX_W bits, is the edge magnitude pixel.
REQ-011 Port edge_valid_o, output, 1 bit, marks edge_o as valid.
REQ-012 Port edge_ready_i, input, 1 bit, is downstream acceptance.
REQ-013 Port edge_last_o, output, 1 bit, is high with the final output pixel of the frame.
REQ-014 Port busy_o, output, 1 bit, is high from start acceptance until done.
REQ-015 Port done_o, output, 1 bit, is a one-cycle pulse after the final output handshake.

Function
REQ-016 The FSM SHALL use states IDLE, RUN, DRAIN and DONE.
- IDLE->RUN on start_i.
- RUN->DRAIN when input pixel IMG_W*IMG_H-1 is accepted.
- DRAIN->DONE on the edge_last_o handshake.
- DONE->IDLE unconditionally after one cycle.
REQ-017 start_i outside IDLE SHALL be ignored.
REQ-018 pix_ready_o SHALL equal (state==RUN) && (!edge_valid_o || edge_ready_i).
- An input handshake is pix_valid_i && pix_ready_o.
REQ-019 Column and row counters SHALL advance on each input handshake.
- Column wraps at IMG_W-1 and increments the row.
REQ-020 Two line buffers of IMG_W entries SHALL hold the previous two rows; a 3x3 window register SHALL shift on each input handshake.
REQ-021 An output SHALL be produced only for an input handshake with row>=2 and col>=2, giving (IMG_W-2)*(IMG_H-2) outputs per frame (no border outputs).
REQ-022 Sobel arithmetic SHALL be signed, PIX_W+3 bits wide, over the window with top-left a and bottom-right i:
- Gx = (c+2f+i)-(a+2d+g).
- Gy = (g+2h+i)-(a+2b+c).
REQ-023 Magnitude SHALL be |Gx|+|Gy|, saturated to 2^PIX_W-1.
REQ-024 Latency SHALL be 1 cycle: the result is registered and edge_valid_o rises on the clock edge of the triggering input handshake.
REQ-025 The output register SHALL hold edge_o, edge_valid_o and edge_last_o stable while edge_valid_o && !edge_ready_i.
REQ-026 A new output loaded in the same cycle as an output handshake SHALL replace the old one with no bubble.
REQ-027 edge_last_o SHALL be high only for the output of input (IMG_H-1, IMG_W-1).
REQ-028 done_o SHALL be high exactly in the DONE state.
REQ-029 busy_o SHALL be high in RUN and DRAIN.

Reset
REQ-030 On rst_ni low, asynchronously:
- FSM goes to IDLE and counters clear to 0.
- edge_o, edge_valid_o, edge_last_o, busy_o, done_o and pix_ready_o are 0.
- The window register is 0.
- Line buffer contents are don't-care.
REQ-031 Reset mid-frame SHALL abandon the frame; the next frame requires a new start_i.

Configuration
REQ-032 With SOBEL_THRESH_EN defined:
- Input port thresh_i (PIX_W bits) SHALL exist.
- edge_o SHALL be all-ones when magnitude>=thresh_i, else 0.
REQ-033 Without SOBEL_THRESH_EN, thresh_i SHALL be absent and edge_o SHALL be the saturated magnitude.

Structure
REQ-034 Package sobel_pkg SHALL hold the FSM state enum, the signed gradient width localparam (PIX_W+3) and the saturation max function.
REQ-035 Sub-module sobel_line_buffer SHALL implement one IMG_W-deep, PIX_W-wide row delay, write-enabled by the input handshake; it is instantiated twice.

Verification
REQ-036 3x3 frame 10,20,...,90 with edge_ready_i=1 -> one output: edge_o=255 (Gx=80, Gy=240, sum 320 saturated), edge_last_o=1, done_o 1 cycle later.
REQ-037 4x4 constant 50 -> four outputs, all 0, with edge_last_o on the 4th output only.
REQ-038 4x4 frame, edge_ready_i toggling 0/1 each cycle -> edge_o held stable while stalled, pix_ready_o low while the output is stalled, no outputs lost or duplicated (4 outputs).
REQ-039 rst_ni low after 5 pixels of a 4x4 frame -> all outputs 0 and IDLE; new start_i and full frame -> correct 4 outputs.
REQ-040 start_i pulsed during RUN -> ignored, output count unchanged; pix_valid_i in IDLE -> pix_ready_o=0.
REQ-041 With SOBEL_THRESH_EN and thresh_i=100, 3x3 frame 10..90 -> edge_o=255; thresh_i=255 with a 3x3 frame whose centre column is 0 and outer columns are 0 and 40 -> Gx=160, edge_o=0.
